// File: rtl/decode_sequencer_pkg.sv
// Shared opcode and phase encodings for the decode sequencer
// and the immediate stage.
package decode_sequencer_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] EN_FETCH  = 4'b0001;
    localparam logic [3:0] EN_DECODE = 4'b0010;
    localparam logic [3:0] EN_EXEC   = 4'b0100;
    localparam logic [3:0] EN_WB     = 4'b1000;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        WB
    } state_e;

    function automatic logic [3:0] phase_en(input state_e s);
        logic [3:0] e;
        e = EN_FETCH;
        unique case (s)
            FETCH:  e = EN_FETCH;
            DECODE: e = EN_DECODE;
            EXEC:   e = EN_EXEC;
            WB:     e = EN_WB;
        endcase
        return e;
    endfunction

    // Branch displacement in bytes from the halfword offset imm[12:1].
    function automatic logic [31:0] branch_disp(input logic [11:0] off);
        return {{19{off[11]}}, off, 1'b0};
    endfunction

endpackage

// File: rtl/instr_field_extract.sv
// Combinational field extraction and immediate formatting.
// Fields unused by the decoded format are forced to zero.
module instr_field_extract
    import decode_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [20:0] imm,
    output logic [11:0] offset,
    output logic        legal
);

    always_comb begin
        opcode = instr[6:0];
        rd     = '0;
        rs1    = '0;
        rs2    = '0;
        funct3 = '0;
        imm    = '0;
        offset = '0;
        legal  = 1'b0;
        unique case (instr[6:0])
            OP_LUI: begin
                rd    = instr[11:7];
                imm   = {1'b0, instr[31:12]};
                legal = 1'b1;
            end
            OP_LOAD: begin
                rd     = instr[11:7];
                rs1    = instr[19:15];
                funct3 = instr[14:12];
                imm    = {{9{instr[31]}}, instr[31:20]};
                legal  = 1'b1;
            end
            OP_BRANCH: begin
                rs1    = instr[19:15];
                rs2    = instr[24:20];
                funct3 = instr[14:12];
                offset = {instr[31], instr[7], instr[30:25], instr[11:8]};
                legal  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_sequencer.sv
// Four-phase fetch/decode/execute/writeback sequencer with
// registered instruction fields and program counter.
module decode_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [11:0] pc_offset,
    output logic [6:0]  OpI,
    output logic [20:0] inmediato,
    output logic [11:0] Offset,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [3:0]  en,
    output logic [31:0] pc,
    output logic        illegal_op
);
    import decode_sequencer_pkg::*;

    state_e      state_q, state_d;
    logic [3:0]  en_q, en_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [6:0]  opi_q, opi_d;
    logic [20:0] imm_q, imm_d;
    logic [11:0] off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [2:0]  f3_q, f3_d;
    logic        ill_q, ill_d;

    logic [31:0] ext_in;
    logic [6:0]  ext_op;
    logic [4:0]  ext_rd, ext_rs1, ext_rs2;
    logic [2:0]  ext_f3;
    logic [20:0] ext_imm;
    logic [11:0] ext_off;
    logic        ext_legal;

    // In FETCH decode the incoming word; afterwards the captured one.
    assign ext_in = (state_q == FETCH) ? instr : ir_q;

    instr_field_extract u_extract (
        .instr  (ext_in),
        .opcode (ext_op),
        .rd     (ext_rd),
        .rs1    (ext_rs1),
        .rs2    (ext_rs2),
        .funct3 (ext_f3),
        .imm    (ext_imm),
        .offset (ext_off),
        .legal  (ext_legal)
    );

    assign instr_ready = (state_q == FETCH) && !halt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opi_d   = opi_q;
        imm_d   = imm_q;
        off_d   = off_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        f3_d    = f3_q;
        ill_d   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (instr_valid && instr_ready) begin
                    ir_d    = instr;
                    opi_d   = ext_op;
                    imm_d   = ext_imm;
                    off_d   = ext_off;
                    rd_d    = ext_rd;
                    rs1_d   = ext_rs1;
                    rs2_d   = ext_rs2;
                    f3_d    = ext_f3;
                    ill_d   = !ext_legal;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (ext_legal) begin
                    state_d = EXEC;
                end else begin
                    state_d = FETCH;
                    pc_d    = pc_q + 32'd4;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                state_d = FETCH;
                if (opi_q == OP_BRANCH && branch_taken)
                    pc_d = pc_q + branch_disp(pc_offset);
                else
                    pc_d = pc_q + 32'd4;
            end
            default: state_d = FETCH;
        endcase
        en_d = phase_en(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            en_q    <= EN_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            opi_q   <= '0;
            imm_q   <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opi_q   <= opi_d;
            imm_q   <= imm_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            f3_q    <= f3_d;
            ill_q   <= ill_d;
        end
    end

    assign OpI        = opi_q;
    assign inmediato  = imm_q;
    assign Offset     = off_q;
    assign rd         = rd_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign funct3     = f3_q;
    assign en         = en_q;
    assign pc         = pc_q;
    assign illegal_op = ill_q;

endmodule
